// File: rtl/band_scheduler_if.sv
// Datapath-side bus of band_scheduler: section handshake, operand, coefficients and result.
// master = scheduler, slave = shared biquad datapath.
interface band_scheduler_if #(
    parameter int size = 21
);
    logic              bq_start;
    logic              bq_done;
    logic [size-1:0]   bq_y;
    logic [size-1:0]   bq_u;
    logic [2:0]        sec;
    logic [size-1:0]   a1;
    logic [size-1:0]   a2;
    logic [size-1:0]   b0;
    logic [size-1:0]   b1;
    logic [size-1:0]   b2;

    modport master (
        output bq_start, bq_u, sec, a1, a2, b0, b1, b2,
        input  bq_done, bq_y
    );

    modport slave (
        input  bq_start, bq_u, sec, a1, a2, b0, b1, b2,
        output bq_done, bq_y
    );
endinterface

// File: rtl/band_scheduler.sv
// Sequences six biquad sections (LP/HP per band) over one shared datapath per sample.
// Optional BQ_WDOG_EN adds a WAIT timeout of TMO cycles that aborts the frame and sets err.
module band_scheduler #(
    parameter int size = 21,
    parameter int pf   = 15,
    parameter int TMO  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EN,
    input  logic [size-1:0] u,
    band_scheduler_if.master bq,
    output logic [size-1:0] y1,
    output logic [size-1:0] y2,
    output logic [size-1:0] y3,
    output logic            valid,
    output logic            busy,
    output logic            ovr,
    output logic            err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      sec_q, sec_d;
    logic [size-1:0] samp_q, samp_d;
    logic [size-1:0] chain_q, chain_d;
    logic [size-1:0] y1_q, y1_d;
    logic [size-1:0] y2_q, y2_d;
    logic [size-1:0] y3_q, y3_d;
    logic            ovr_q, ovr_d;
    logic            err_q, err_d;
    logic [104:0]    coef_w;

    // Configuration sanity term; pf is documentation-only for this block.
    logic cfg_unused;
    assign cfg_unused = (pf < size) ^ (TMO > 0);

`ifdef BQ_WDOG_EN
    localparam int unsigned CW = $clog2(TMO + 1);
    logic [CW-1:0] wdog_q, wdog_d;
`endif

    // Rows packed as {a1, a2, b0, b1, b2}, 21-bit two's complement.
    always_comb begin
        coef_w = '0;
        case (sec_q)
            3'd0: coef_w = {21'h00FAE1, 21'h1F850E, 21'h000007, 21'h00000D, 21'h000007};
            3'd1: coef_w = {21'h00FF7D, 21'h1F8083, 21'h007FBE, 21'h1F00FF, 21'h007FBE};
            3'd2: coef_w = {21'h00847B, 21'h1FD0EC, 21'h000AA5, 21'h001549, 21'h000AA5};
            3'd3: coef_w = {21'h00FAE1, 21'h1F850E, 21'h008000, 21'h1F0000, 21'h008000};
            3'd4: coef_w = {21'h1F345A, 21'h1FAB4D, 21'h006817, 21'h00D021, 21'h006817};
            3'd5: coef_w = {21'h00847B, 21'h1FD0EC, 21'h004CE4, 21'h1F6646, 21'h004CE4};
            default: coef_w = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        samp_d  = samp_q;
        chain_d = chain_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        y3_d    = y3_q;
        ovr_d   = ovr_q | (EN & (state_q != S_IDLE));
        err_d   = err_q;
`ifdef BQ_WDOG_EN
        wdog_d  = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    samp_d  = u;
                    sec_d   = 3'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef BQ_WDOG_EN
                wdog_d  = '0;
`endif
            end
            S_WAIT: begin
                if (bq.bq_done) begin
                    chain_d = bq.bq_y;
                    case (sec_q)
                        3'd1:    y1_d = bq.bq_y;
                        3'd3:    y2_d = bq.bq_y;
                        3'd5:    y3_d = bq.bq_y;
                        default: ;
                    endcase
                    if (sec_q == 3'd5) begin
                        state_d = S_DONE;
                    end else begin
                        sec_d   = sec_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end
`ifdef BQ_WDOG_EN
                else if ((wdog_q + CW'(1)) == CW'(TMO)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_q + CW'(1);
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sec_q   <= '0;
            samp_q  <= '0;
            chain_q <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y3_q    <= '0;
            ovr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            samp_q  <= samp_d;
            chain_q <= chain_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y3_q    <= y3_d;
            ovr_q   <= ovr_d;
            err_q   <= err_d;
        end
    end

`ifdef BQ_WDOG_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
    assign err = err_q;
`else
    logic err_unused;
    assign err_unused = err_q | err_d;
    assign err = 1'b0;
`endif

    // Even sections take the band input, odd sections chain from the preceding LP stage.
    assign bq.bq_u     = sec_q[0] ? chain_q : samp_q;
    assign bq.sec      = sec_q;
    assign bq.bq_start = (state_q == S_ISSUE);
    assign bq.a1       = size'(signed'(coef_w[104:84]));
    assign bq.a2       = size'(signed'(coef_w[83:63]));
    assign bq.b0       = size'(signed'(coef_w[62:42]));
    assign bq.b1       = size'(signed'(coef_w[41:21]));
    assign bq.b2       = size'(signed'(coef_w[20:0]));

    assign y1    = y1_q;
    assign y2    = y2_q;
    assign y3    = y3_q;
    assign valid = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE);
    assign ovr   = ovr_q;

endmodule

// File: tb/tb_band_scheduler.sv
// Directed bench for band_scheduler with a behavioural datapath (latency/offset configurable).
module tb_band_scheduler;

    localparam int TB_TMO = 8;

    logic        clk;
    logic        rst;
    logic        EN;
    logic [20:0] u;
    logic [20:0] y1, y2, y3;
    logic        valid, busy, ovr, err;

    band_scheduler_if #(.size(21)) dif ();

    band_scheduler #(.size(21), .pf(15), .TMO(TB_TMO)) dut (
        .clk   (clk),
        .rst   (rst),
        .EN    (EN),
        .u     (u),
        .bq    (dif),
        .y1    (y1),
        .y2    (y2),
        .y3    (y3),
        .valid (valid),
        .busy  (busy),
        .ovr   (ovr),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          npass = 0;
    int          nchk  = 0;
    int          dp_lat = 1;
    int          dp_cnt = 0;
    bit          dp_en  = 1'b1;
    logic [20:0] dp_off = '0;

    logic [20:0] ctab [0:5][0:4] = '{
        '{21'h00FAE1, 21'h1F850E, 21'h000007, 21'h00000D, 21'h000007},
        '{21'h00FF7D, 21'h1F8083, 21'h007FBE, 21'h1F00FF, 21'h007FBE},
        '{21'h00847B, 21'h1FD0EC, 21'h000AA5, 21'h001549, 21'h000AA5},
        '{21'h00FAE1, 21'h1F850E, 21'h008000, 21'h1F0000, 21'h008000},
        '{21'h1F345A, 21'h1FAB4D, 21'h006817, 21'h00D021, 21'h006817},
        '{21'h00847B, 21'h1FD0EC, 21'h004CE4, 21'h1F6646, 21'h004CE4}
    };

    // Datapath model: done arrives dp_lat cycles after the bq_start cycle, bq_y = bq_u + dp_off.
    initial begin
        dif.bq_done = 1'b0;
        dif.bq_y    = '0;
        forever begin
            @(posedge clk);
            #1;
            dif.bq_done = 1'b0;
            if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0 && dp_en) begin
                    dif.bq_done = 1'b1;
                    dif.bq_y    = dif.bq_u + dp_off;
                end
            end
            if (dif.bq_start === 1'b1) dp_cnt = dp_lat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Ticks until valid is seen (bounded); leaves time in the valid cycle.
    task automatic wait_valid(input string tag);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (valid === 1'b1) got = 1'b1;
            else tick();
        end
        chk(tag, {31'd0, got}, 32'd1);
    endtask

    bit          saw;
    int unsigned exp_sec;

    initial begin
        rst = 1'b0;
        EN  = 1'b1;
        u   = 21'h0ABCDE;

        // Reset held two cycles with EN asserted
        tick();
        tick();
        chk("rst_y1", y1, 0);
        chk("rst_y2", y2, 0);
        chk("rst_y3", y3, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_err", err, 0);
        chk("rst_start", dif.bq_start, 0);
        chk("rst_sec", dif.sec, 0);
        chk("rst_bq_u", dif.bq_u, 0);
        EN  = 1'b0;
        rst = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Identity datapath, 1-cycle latency: cycle-exact schedule
        dp_lat = 1;
        dp_off = '0;
        u  = 21'h001234;
        EN = 1'b1;
        tick();
        EN = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            chk($sformatf("id_start_c%0d", c), dif.bq_start, ((c % 2 == 1) && c <= 11) ? 1 : 0);
            chk($sformatf("id_valid_c%0d", c), valid, (c == 13) ? 1 : 0);
            if (c % 2 == 1 && c <= 11) begin
                chk($sformatf("id_sec_c%0d", c), dif.sec, (c - 1) / 2);
                chk($sformatf("id_bq_u_c%0d", c), dif.bq_u, 32'h1234);
            end
            if (c < 13) tick();
        end
        chk("id_y1", y1, 32'h1234);
        chk("id_y2", y2, 32'h1234);
        chk("id_y3", y3, 32'h1234);
        tick();
        chk("id_busy_c14", busy, 0);
        chk("id_valid_c14", valid, 0);

        // bq_y = bq_u + 1, 3-cycle latency; operands and coefficient rows per section
        dp_lat = 3;
        dp_off = 21'd1;
        u  = 21'd10;
        EN = 1'b1;
        tick();
        EN = 1'b0;
        exp_sec = 0;
        saw = 1'b0;
        for (int c = 0; c < 80 && !saw; c++) begin
            if (dif.bq_start === 1'b1) begin
                chk($sformatf("p3_sec%0d", exp_sec), dif.sec, exp_sec);
                chk($sformatf("p3_bq_u%0d", exp_sec), dif.bq_u, (exp_sec % 2 == 0) ? 10 : 11);
                if (exp_sec < 6) begin
                    chk($sformatf("p3_a1_s%0d", exp_sec), dif.a1, ctab[exp_sec][0]);
                    chk($sformatf("p3_a2_s%0d", exp_sec), dif.a2, ctab[exp_sec][1]);
                    chk($sformatf("p3_b0_s%0d", exp_sec), dif.b0, ctab[exp_sec][2]);
                    chk($sformatf("p3_b1_s%0d", exp_sec), dif.b1, ctab[exp_sec][3]);
                    chk($sformatf("p3_b2_s%0d", exp_sec), dif.b2, ctab[exp_sec][4]);
                end
                exp_sec++;
            end
            if (valid === 1'b1) saw = 1'b1;
            else tick();
        end
        chk("p3_valid_seen", {31'd0, saw}, 1);
        chk("p3_nsections", exp_sec, 6);
        chk("p3_y1", y1, 12);
        chk("p3_y2", y2, 12);
        chk("p3_y3", y3, 12);
        tick();

        // Overrun: second EN in cycle 5 of the frame is dropped
        dp_lat = 1;
        dp_off = '0;
        u  = 21'h000ABC;
        EN = 1'b1;
        tick();
        EN = 1'b0;
        tick(); tick(); tick(); tick();
        u  = 21'h000777;
        EN = 1'b1;
        tick();
        EN = 1'b0;
        chk("ovr_set", ovr, 1);
        wait_valid("ovr_valid");
        chk("ovr_y1", y1, 32'hABC);
        chk("ovr_y3", y3, 32'hABC);
        tick();
        tick();
        tick();
        chk("ovr_no_frame", busy, 0);
        chk("ovr_sticky", ovr, 1);

        // Reset during sec=3 WAIT aborts the frame
        u  = 21'h000055;
        EN = 1'b1;
        tick();
        EN = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        chk("mid_sec3", dif.sec, 3);
        chk("mid_wait", {30'd0, busy, dif.bq_start}, 32'h2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_busy", busy, 0);
        chk("mid_y1", y1, 0);
        chk("mid_y2", y2, 0);
        chk("mid_sec", dif.sec, 0);
        chk("mid_ovr", ovr, 0);
        saw = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (valid === 1'b1 || busy === 1'b1) saw = 1'b1;
            tick();
        end
        chk("mid_quiet", {31'd0, saw}, 0);
        u  = 21'h1F0001;
        EN = 1'b1;
        tick();
        EN = 1'b0;
        chk("fresh_start", dif.bq_start, 1);
        wait_valid("fresh_valid");
        chk("fresh_y1", y1, 32'h1F0001);
        chk("fresh_y2", y2, 32'h1F0001);
        chk("fresh_y3", y3, 32'h1F0001);
        tick();

`ifdef BQ_WDOG_EN
        // Watchdog: datapath never answers
        dp_en = 1'b0;
        u  = 21'h000321;
        EN = 1'b1;
        tick();
        EN = 1'b0;
        for (int c = 1; c < 9; c++) tick();
        chk("wd_busy_c9", busy, 1);
        chk("wd_err_c9", err, 0);
        tick();
        chk("wd_busy_c10", busy, 0);
        chk("wd_err_c10", err, 1);
        chk("wd_valid_c10", valid, 0);
        dp_en = 1'b1;
        EN = 1'b1;
        tick();
        EN = 1'b0;
        chk("wd_restart_start", dif.bq_start, 1);
        chk("wd_restart_sec", dif.sec, 0);
        wait_valid("wd_restart_valid");
        chk("wd_err_sticky", err, 1);
`else
        chk("err_tied", err, 0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
